// File: rtl/icarus_pkg.sv
// Shared field constants and types for the p = 2^255 - 19 arithmetic datapath.
package icarus_pkg;

  localparam int unsigned FIELD_N = 256;
  localparam int unsigned FIELD_C = 19;
  localparam logic [255:0] FIELD_P = (256'd1 << 255) - 256'd19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FOLD1 = 3'd1,
    FOLD2 = 3'd2,
    CSUB  = 3'd3,
    DONE  = 3'd4
  } red_state_t;

  typedef logic [255:0] fe_t;

endpackage

// File: rtl/mod_fold.sv
// Combinational pseudo-Mersenne fold: y = x[LO_W-1:0] + C * x[W-1:LO_W].
module mod_fold #(
  parameter int unsigned W    = 263,
  parameter int unsigned C    = 19,
  parameter int unsigned LO_W = 255,
  // Product needs (W-LO_W)+8 bits for C < 2^8, plus one bit for the carry out of the add.
  parameter int unsigned OW   = (((W - LO_W + 8) > LO_W) ? (W - LO_W + 8) : LO_W) + 1
) (
  input  logic [W-1:0]  x,
  output logic [OW-1:0] y
);

  localparam int unsigned HW = W - LO_W;

  logic [LO_W-1:0] lo;
  logic [HW-1:0]   hi;

  assign lo = x[LO_W-1:0];
  assign hi = x[W-1:LO_W];
  assign y  = OW'(lo) + OW'(hi) * OW'(C);

endmodule

// File: rtl/mod_reduce.sv
// Iterative reduction of a 2N-bit product to its canonical residue mod 2^(N-1) - C.
module mod_reduce
  import icarus_pkg::*;
#(
  parameter int unsigned N = FIELD_N,
  parameter int unsigned C = FIELD_C
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   res,
  output logic [2:0]     state
);

  localparam int unsigned PW   = 2 * N;
  localparam int unsigned LO_W = N - 1;
  // After the first fold the value is below 2^(N+7) for small C, so the second fold only sees 8 high bits.
  localparam int unsigned XW   = N + 7;
  localparam int unsigned FW   = (((PW - LO_W + 8) > LO_W) ? (PW - LO_W + 8) : LO_W) + 1;
  localparam logic [N-1:0] P_MOD = (N'(1) << (N - 1)) - N'(C);

  red_state_t     state_q;
  red_state_t     state_d;
  logic [PW-1:0]  x;
  logic [PW-1:0]  fold_in;
  logic [FW-1:0]  fold_out;
  logic [N-1:0]   x_lo;
  logic [N-1:0]   res_d;

  // One fold instance serves both passes; FOLD2 sees only the narrow intermediate.
  assign fold_in = (state_q == FOLD1) ? x : PW'(x[XW-1:0]);

  mod_fold #(
    .W    (PW),
    .C    (C),
    .LO_W (LO_W),
    .OW   (FW)
  ) u_fold (
    .x (fold_in),
    .y (fold_out)
  );

  assign x_lo  = x[N-1:0];
  assign res_d = (x_lo >= P_MOD) ? (x_lo - P_MOD) : x_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = FOLD1;
      FOLD1:   state_d = FOLD2;
      FOLD2:   state_d = CSUB;
      CSUB:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    state     = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      res <= '0;
    end else begin
      case (state_q)
        IDLE:        if (in_valid) x <= prod;
        FOLD1, FOLD2: x <= PW'(fold_out);
        CSUB:        res <= res_d;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce.sv
// Directed bench for mod_reduce: residue scoreboard via prod % p plus literal pins.
module tb_mod_reduce;

  localparam logic [511:0] P512 = (512'd1 << 255) - 512'd19;
  localparam logic [255:0] P256 = (256'd1 << 255) - 256'd19;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] prod;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] res;
  logic [2:0]   state;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Behavioural model: cycles since acceptance (0 = idle, 4 = result presented) and expected residues.
  logic [2:0]   age;
  logic [255:0] exp_q[$];

  mod_reduce #(.N(256), .C(19)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= 3'd0;
      exp_q.delete();
    end else if (age == 3'd0) begin
      if (in_valid) begin
        exp_q.push_back(256'(prod % P512));
        age <= 3'd1;
      end
    end else if (age < 3'd4) begin
      age <= age + 3'd1;
    end else if (out_ready) begin
      void'(exp_q.pop_front());
      age <= 3'd0;
    end
  end

  always @(negedge clk) begin
    check("in_ready", 512'(in_ready), 512'(age == 3'd0));
    check("out_valid", 512'(out_valid), 512'(age == 3'd4));
    check("state", 512'(state), 512'(age));
    if (age == 3'd4) begin
      if (exp_q.size() > 0) check("res_model", 512'(res), 512'(exp_q[0]));
      else check("scoreboard_entry", 512'(exp_q.size()), 512'd1);
    end
  end

  task automatic run_one(input logic [511:0] v, input logic [255:0] lit,
                         input int unsigned hold, input bit noise);
    int unsigned n;
    logic [255:0] r0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_ready", 512'(in_ready), 512'd1);
    prod      = v;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_edges_after_accept", 512'(n), 512'd3);
    check("res_literal", 512'(res), 512'(lit));
    r0 = res;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (noise) begin
        in_valid = ~i[0];
        prod     = ~v ^ 512'(i);
      end
      @(posedge clk);
      #1;
      check("hold_res", 512'(res), 512'(r0));
      check("hold_out_valid", 512'(out_valid), 512'd1);
      check("hold_in_ready", 512'(in_ready), 512'd0);
      check("hold_state", 512'(state), 512'd4);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("back_to_idle", 512'(state), 512'd0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prod      = '0;
    #1;
    check("rst_state", 512'(state), 512'd0);
    check("rst_in_ready", 512'(in_ready), 512'd1);
    check("rst_out_valid", 512'(out_valid), 512'd0);
    check("rst_res", 512'(res), 512'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_one(512'h3c, 256'h3c, 0, 1'b0);
    run_one(P512, 256'd0, 0, 1'b0);
    run_one(P512 - 512'd1, P256 - 256'd1, 0, 1'b0);
    run_one((512'd1 << 256) - 512'd39, P256 - 256'd1, 0, 1'b0);
    run_one(512'd1 << 255, 256'h13, 0, 1'b0);
    run_one((512'd1 << 257) - 512'd2, 256'h4a, 0, 1'b0);
    run_one({512{1'b1}}, 256'h5a3, 0, 1'b0);

    // Backpressure with ignored traffic on the input side.
    run_one((512'd1 << 300) + 512'd12345, 256'(((512'd1 << 300) + 512'd12345) % P512), 10, 1'b1);

    // Abort during FOLD2.
    @(negedge clk);
    prod     = {512{1'b1}};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_abort_state", 512'(state), 512'd2);
    rst = 1'b1;
    #1;
    check("abort_state", 512'(state), 512'd0);
    check("abort_out_valid", 512'(out_valid), 512'd0);
    check("abort_res", 512'(res), 512'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_one((512'd1 << 255) + 512'd5, 256'h18, 0, 1'b0);

    // Back-to-back with out_ready tied high.
    @(negedge clk);
    out_ready = 1'b1;
    prod      = 512'd1234567;
    in_valid  = 1'b1;
    repeat (10) @(negedge clk);
    in_valid  = 1'b0;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
